tone_demod: RTL
===============

# tone_demod

Single-bin quadrature correlator that receives a tone at fs/16 and recovers its in-phase and quadrature content over a fixed integration window. It multiplies each accepted sample by a 16-entry signed sine table (0, 38, 71, 92, 100, 92, 71, 38, 0, −38, −71, −92, −100, −92, −71, −38) and by the matching cosine entry (the sine entry at (k+4) mod 16), then accumulates both products. It sits on the receive side of the LO path and measures whatever the LO-driven chain delivers. Results are presented through a valid/ready output handshake.

## Interface
- DATA_W, 9: input sample width, signed two's complement.
- NPER, 4: tone periods per window; window = 16·NPER samples; NPER ≥ 1.
- ACC_W, 24: accumulator and output width. Must satisfy ACC_W ≥ DATA_W + 10 + clog2(NPER); legal ranges then cannot overflow.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  begin a window; sampled only in IDLE, or in HOLD on the handshake cycle.
- in_valid  in  1  in_sample is valid this cycle.
- in_sample  in  DATA_W  signed input sample.
- i_out  out  ACC_W  signed Σ x·sin[k].
- q_out  out  ACC_W  signed Σ x·cos[k].
- out_valid  out  1  i_out/q_out hold a completed result.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  high in ACC.

## Operation
- States:
  - IDLE: accumulators are not touched.
  - ACC: accumulating.
  - HOLD: result presented.
- IDLE → ACC when start=1. On that edge: clear both accumulators, table index k=0, sample count n=0.
- ACC, in_valid=1 (one accepted sample):
  - acc_i += x·sin[k]; acc_q += x·sin[(k+4) mod 16].
  - k wraps 15 → 0; n increments.
  - Products are full precision (DATA_W+8 bits), sign-extended to ACC_W.
- ACC, in_valid=0: no change; gaps of any length are allowed.
- ACC → HOLD on the edge that accepts sample n = 16·NPER−1. That edge also writes the final sums to i_out/q_out.
- HOLD: i_out, q_out and out_valid are stable until out_ready=1.
  - out_ready=1 and start=0 → IDLE.
  - out_ready=1 and start=1 → ACC directly, with accumulators cleared.
- Ignored inputs:
  - start in ACC, and start in HOLD without out_ready.
  - in_valid outside ACC; no samples are buffered.
- i_out/q_out change only on entry to HOLD. In IDLE they retain the last result.
- Reset (rst_n=0 at a rising edge, any state, including mid-window):
  - state=IDLE; k=0, n=0; accumulators=0.
  - i_out=0, q_out=0, out_valid=0, busy=0; mag_out=0 when compiled in.
  - Any partial window is discarded.

## Timing
- Accepting a sample: the accumulator updates on the same rising edge (1-cycle MAC, no pipeline).
- Latency: out_valid=1 in the cycle after the edge that accepted the last sample.
- Minimum window length: 16·NPER cycles with in_valid held high.
- busy rises the cycle after start is taken and falls together with the rise of out_valid.
- Handshake completes on a rising edge where out_valid && out_ready. out_valid is low in the following cycle unless a restart is taken; after a restart it stays low until the next window completes.
- Back-to-back windows: start held high gives one dead cycle (the HOLD cycle) between windows when out_ready is high.

## Configuration
- TONE_DEMOD_MAG_EN defined:
  - Adds output port mag_out, unsigned, ACC_W+1 bits, equal to |i_out| + |q_out| (L1 magnitude estimate).
  - mag_out is registered on the same edge as i_out/q_out, so it is valid with out_valid and shares the same hold and reset behaviour.
- Not defined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with start=1 and in_valid=1 → i_out=0, q_out=0, out_valid=0, busy=0 (mag_out=0 when enabled).
- Aligned sine: NPER=4, start, then 64 consecutive samples 0, 38, 71 … −38 repeating → out_valid 1 cycle after the 64th sample, I=319184, Q=0 (mag_out=319184).
- Cosine (sine shifted by 4): same setup → I=0, Q=319184. Inverted sine → I=−319184, Q=0.
- DC input of 100 for 64 samples, with in_valid toggled randomly (50% gaps) → I=0, Q=0; busy stays high until the 64th accepted sample.
- Backpressure: after a result, out_ready=0 for 10 cycles while start pulses and in_valid=1 → outputs stable, no new window. Then out_ready=1 with start=1 → direct restart; the next aligned window again gives I=319184.
- Reset after 20 samples mid-ACC → IDLE with all outputs 0. A fresh aligned-sine window then gives exactly I=319184, Q=0.

Source files
------------

// File: rtl/tone_demod.sv
// tone_demod
// Single-bin quadrature correlator for a tone at fs/16. Each accepted sample
// is multiplied by a 16-entry signed sine table and by the matching cosine
// entry, which is the sine entry four steps ahead. Both products are summed
// over a window of 16*NPER accepted samples. The finished sums are then held
// on i_out/q_out behind a valid/ready handshake.
//
// Optional feature: define TONE_DEMOD_MAG_EN to add mag_out = |i_out| + |q_out|.
//
// Parameters:
//   DATA_W  input sample width (signed)
//   NPER    tone periods per window (window = 16*NPER samples)
//   ACC_W   accumulator/output width, at least DATA_W + 10 + clog2(NPER)
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      begin a window (taken in IDLE, or in HOLD on the handshake cycle)
//   in_valid   in_sample is valid this cycle
//   in_sample  signed input sample
//   i_out      signed sum of x*sin[k]
//   q_out      signed sum of x*cos[k]
//   out_valid  i_out/q_out hold a completed result
//   out_ready  consumer accepts the result
//   busy       window in progress
//   mag_out    (TONE_DEMOD_MAG_EN only) unsigned |i_out| + |q_out|

module tone_demod #(
  parameter int DATA_W = 9,
  parameter int NPER   = 4,
  parameter int ACC_W  = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_sample,
  output logic signed [ACC_W-1:0]  i_out,
  output logic signed [ACC_W-1:0]  q_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
`ifdef TONE_DEMOD_MAG_EN
  ,
  output logic [ACC_W:0]           mag_out
`endif
);

  localparam int WIN    = 16 * NPER;
  localparam int N_W    = $clog2(WIN);
  localparam int PROD_W = DATA_W + 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // Sine table, amplitude 100, one full period over 16 entries.
  function automatic logic signed [7:0] sine_at(input logic [3:0] idx);
    logic signed [7:0] v;
    case (idx)
      4'd0:    v = 8'sd0;
      4'd1:    v = 8'sd38;
      4'd2:    v = 8'sd71;
      4'd3:    v = 8'sd92;
      4'd4:    v = 8'sd100;
      4'd5:    v = 8'sd92;
      4'd6:    v = 8'sd71;
      4'd7:    v = 8'sd38;
      4'd8:    v = 8'sd0;
      4'd9:    v = -8'sd38;
      4'd10:   v = -8'sd71;
      4'd11:   v = -8'sd92;
      4'd12:   v = -8'sd100;
      4'd13:   v = -8'sd92;
      4'd14:   v = -8'sd71;
      default: v = -8'sd38;
    endcase
    return v;
  endfunction

`ifdef TONE_DEMOD_MAG_EN
  // The most negative value maps to 2^(ACC_W-1), which still fits unsigned.
  function automatic logic [ACC_W-1:0] abs_val(input logic signed [ACC_W-1:0] v);
    return v[ACC_W-1] ? -v : v;
  endfunction
`endif

  logic [1:0]               state;
  logic [3:0]               k;
  logic [N_W-1:0]           n;
  logic signed [ACC_W-1:0]  acc_i;
  logic signed [ACC_W-1:0]  acc_q;

  logic signed [7:0]        sin_k;
  logic signed [7:0]        cos_k;
  logic signed [PROD_W-1:0] prod_i;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [ACC_W-1:0]  sum_i;
  logic signed [ACC_W-1:0]  sum_q;
  logic                     last;

  // The 4-bit index wraps by itself, so k+4 is the mod-16 cosine lookup.
  assign sin_k  = sine_at(k);
  assign cos_k  = sine_at(k + 4'd4);

  // Both operands are widened to the full product width before multiplying,
  // so the product is exact; it is then sign-extended into the accumulator.
  assign prod_i = PROD_W'(in_sample) * PROD_W'(sin_k);
  assign prod_q = PROD_W'(in_sample) * PROD_W'(cos_k);
  assign sum_i  = acc_i + ACC_W'(prod_i);
  assign sum_q  = acc_q + ACC_W'(prod_q);
  assign last   = (n == N_W'(WIN - 1));

  assign out_valid = (state == S_HOLD);
  assign busy      = (state == S_ACC);

  // Window control and single-cycle multiply-accumulate. Output registers
  // load only on the edge that accepts the final sample of a window.
  // A restart from HOLD clears the accumulators just like a start from IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      k     <= '0;
      n     <= '0;
      acc_i <= '0;
      acc_q <= '0;
      i_out <= '0;
      q_out <= '0;
`ifdef TONE_DEMOD_MAG_EN
      mag_out <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ACC;
            acc_i <= '0;
            acc_q <= '0;
            k     <= '0;
            n     <= '0;
          end
        end
        S_ACC: begin
          if (in_valid) begin
            acc_i <= sum_i;
            acc_q <= sum_q;
            k     <= k + 4'd1;
            n     <= n + 1'b1;
            if (last) begin
              state <= S_HOLD;
              i_out <= sum_i;
              q_out <= sum_q;
`ifdef TONE_DEMOD_MAG_EN
              mag_out <= {1'b0, abs_val(sum_i)} + {1'b0, abs_val(sum_q)};
`endif
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            if (start) begin
              state <= S_ACC;
              acc_i <= '0;
              acc_q <= '0;
              k     <= '0;
              n     <= '0;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
